// File: rtl/binarization_pkg.sv
// Shared types and constants for the binarization threshold path.
package binarization_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CHECK  = 2'd2,
        UPDATE = 2'd3
    } state_e;

    localparam int           PIX_W   = 17;
    localparam int           THR_W   = 8;
    localparam logic [7:0]   PIX_SAT = 8'd255;

endpackage

// File: rtl/binarization_pix_sat.sv
// Combinational 17->8 bit pixel saturation, shared with the comparator path.
module binarization_pix_sat
    import binarization_pkg::*;
(
    input  logic [PIX_W-1:0] pix_i,
    output logic [THR_W-1:0] pix8_o
);

    assign pix8_o = (pix_i > PIX_W'(PIX_SAT)) ? PIX_SAT : pix_i[THR_W-1:0];

endmodule

// File: rtl/binarization_threshold_gen.sv
// Frame-mean threshold producer: averages saturated pixels of a 2**LOG2_PIX frame.
// Optional output clamp to [THR_LO, THR_HI] is enabled by defining THR_CLAMP_EN.
module binarization_threshold_gen
    import binarization_pkg::*;
#(
    parameter int               LOG2_PIX = 16,
    parameter logic [THR_W-1:0] INIT_THR = 8'd128,
    parameter logic [THR_W-1:0] THR_LO   = 8'd16,
    parameter logic [THR_W-1:0] THR_HI   = 8'd240
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic [THR_W-1:0] threshold,
    output logic             thr_valid,
    output logic             frame_err
);

    localparam int               SUM_W    = THR_W + LOG2_PIX;
    localparam int               CNT_W    = LOG2_PIX + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << LOG2_PIX;
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_FULL + CNT_W'(1);

    if (THR_LO > THR_HI) begin : g_bad_clamp
        $error("THR_LO must not exceed THR_HI");
    end

    function automatic logic [THR_W-1:0] thr_map(input logic [THR_W-1:0] m);
`ifdef THR_CLAMP_EN
        if (m < THR_LO)      return THR_LO;
        else if (m > THR_HI) return THR_HI;
        else                 return m;
`else
        return m;
`endif
    endfunction

    state_e           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [THR_W-1:0] thr_q, thr_d;
    logic             thr_valid_q, thr_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [THR_W-1:0] pix8;
    logic             fire;

    binarization_pix_sat u_pix_sat (
        .pix_i  (in_data),
        .pix8_o (pix8)
    );

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign fire     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        count_d     = count_q;
        thr_d       = thr_q;
        thr_valid_d = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire && in_sof) begin
                    sum_d   = SUM_W'(pix8);
                    count_d = CNT_W'(1);
                    state_d = in_eof ? CHECK : ACCUM;
                end
            end
            ACCUM: begin
                if (fire) begin
                    if (in_sof) begin
                        frame_err_d = 1'b1;
                        sum_d       = SUM_W'(pix8);
                        count_d     = CNT_W'(1);
                    end else begin
                        sum_d   = sum_q + SUM_W'(pix8);
                        // Sticky at N+1 so an overrun can never wrap back to a valid length.
                        count_d = (count_q == CNT_OVR) ? count_q : count_q + CNT_W'(1);
                    end
                    if (in_eof) state_d = CHECK;
                end
            end
            CHECK: begin
                if (count_q == CNT_FULL) begin
                    state_d = UPDATE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            UPDATE: begin
                // The top THR_W bits of the sum are exactly sum >> LOG2_PIX.
                thr_d       = thr_map(sum_q[SUM_W-1 -: THR_W]);
                thr_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            thr_q       <= INIT_THR;
            thr_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            thr_q       <= thr_d;
            thr_valid_q <= thr_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign threshold = thr_q;
    assign thr_valid = thr_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_binarization_threshold_gen.sv
// Directed bench for binarization_threshold_gen with a 16-pixel frame.
module tb_binarization_threshold_gen;
    import binarization_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof   = 1'b0;
    logic        in_eof   = 1'b0;
    logic [16:0] in_data  = '0;
    logic        in_ready;
    logic [7:0]  threshold;
    logic        thr_valid;
    logic        frame_err;

    int checks  = 0;
    int errors  = 0;
    int thr_cnt = 0;
    int err_cnt = 0;

`ifdef THR_CLAMP_EN
    localparam int EXP_LOW  = 16;
    localparam int EXP_HIGH = 240;
`else
    localparam int EXP_LOW  = 5;
    localparam int EXP_HIGH = 250;
`endif

    binarization_threshold_gen #(
        .LOG2_PIX (4),
        .INIT_THR (8'd128),
        .THR_LO   (8'd16),
        .THR_HI   (8'd240)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .threshold (threshold),
        .thr_valid (thr_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (thr_valid === 1'b1) thr_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns cycles spent stalled.
    task automatic beat(input logic [16:0] d, input logic sof, input logic eof, output int stalls);
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_eof   = eof;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic frame(input logic [16:0] v, input int len);
        int st;
        for (int i = 0; i < len; i++) beat(v, i == 0, i == len - 1, st);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame_chk(input string tag, input logic [16:0] v, input int len,
                             input int exp_thr, input int exp_upd, input int exp_err);
        int t0, e0;
        t0 = thr_cnt;
        e0 = err_cnt;
        frame(v, len);
        settle();
        chk({tag, "_thr"}, threshold, exp_thr);
        chk({tag, "_upd"}, thr_cnt - t0, exp_upd);
        chk({tag, "_err"}, err_cnt - e0, exp_err);
    endtask

    initial begin
        int st, t0, e0;

        // T1 reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_thr", threshold, 128);
        chk("rst_thr_valid", thr_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_in_ready", in_ready, 1);
        #30 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_thr", threshold, 128);
        chk("rel_thr_valid", thr_valid, 0);
        chk("rel_frame_err", frame_err, 0);
        chk("rel_in_ready", in_ready, 1);

        // T2 uniform frame with exact latency
        t0 = thr_cnt;
        for (int i = 0; i < 16; i++) beat(17'd100, i == 0, i == 15, st);
        chk("t2_check_ready", in_ready, 0);
        chk("t2_check_thr_valid", thr_valid, 0);
        @(posedge clk); #1;
        chk("t2_update_ready", in_ready, 0);
        chk("t2_update_thr_valid", thr_valid, 0);
        chk("t2_update_thr_old", threshold, 128);
        @(posedge clk); #1;
        chk("t2_thr_valid", thr_valid, 1);
        chk("t2_thr", threshold, 100);
        chk("t2_ready_back", in_ready, 1);
        @(posedge clk); #1;
        chk("t2_thr_valid_drop", thr_valid, 0);
        chk("t2_pulses", thr_cnt - t0, 1);

        // T3 saturation
        frame_chk("t3_sat", 17'h1FFFF, 16, 255, 1, 0);
        t0 = thr_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 16; i++) beat((i < 8) ? 17'd0 : 17'd300, i == 0, i == 15, st);
        settle();
        chk("t3_mix_thr", threshold, 127);
        chk("t3_mix_upd", thr_cnt - t0, 1);
        chk("t3_mix_err", err_cnt - e0, 0);

        // T4 short frame, then recovery
        frame_chk("t4_short", 17'd10, 11, 127, 0, 1);
        frame_chk("t4_good", 17'd200, 16, 200, 1, 0);

        // Overrun: 17 beats before eof
        frame_chk("ovr", 17'd30, 17, 200, 0, 1);

        // T5 restart on beat 7
        t0 = thr_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 7; i++) beat(17'd77, i == 0, 1'b0, st);
        frame(17'd50, 16);
        settle();
        chk("t5_thr", threshold, 50);
        chk("t5_upd", thr_cnt - t0, 1);
        chk("t5_err", err_cnt - e0, 1);

        // T6 clamp bounds
        frame_chk("t6_low", 17'd5, 16, EXP_LOW, 1, 0);
        frame_chk("t6_high", 17'd250, 16, EXP_HIGH, 1, 0);

        // T7 backpressure: next sof offered straight after eof
        t0 = thr_cnt;
        e0 = err_cnt;
        frame(17'd60, 16);
        beat(17'd90, 1'b1, 1'b0, st);
        chk("t7_stall_cycles", st, 2);
        chk("t7_first_thr", threshold, 60);
        for (int i = 1; i < 16; i++) beat(17'd90, 1'b0, i == 15, st);
        settle();
        chk("t7_thr", threshold, 90);
        chk("t7_upd", thr_cnt - t0, 2);
        chk("t7_err", err_cnt - e0, 0);

        // Asynchronous reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) beat(17'd33, i == 0, 1'b0, st);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_thr", threshold, 128);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_thr_valid", thr_valid, 0);
        #10 rst_n = 1'b1;

        // Beats without sof in IDLE are dropped
        for (int i = 0; i < 3; i++) beat(17'd200, 1'b0, 1'b0, st);
        frame_chk("post_rst", 17'd20, 16, 20, 1, 0);

        // Single-beat frame (sof and eof together) is too short
        frame_chk("one_beat", 17'd99, 1, 20, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
